mealy_share_ctrl: RTL

Round-robin controller that time-shares one Mealy rising-edge detector among NREQ serial requesters. Each granted requester streams one fixed-length frame of bits into the detector. The controller counts detector hits over the frame and reports the count with the requester index. It sits between the requester channels and the single shared detector instance. The detector is the team's existing block: `aout = ain & state`, state reloads to 1 on its sync reset, otherwise to `~ain`.

---
 rtl/mealy_share_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mealy_share_ctrl.sv
// Round-robin controller that time-shares one Mealy rising-edge detector among
// NREQ serial requesters, counting detector hits over one fixed-length frame per grant.
module mealy_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 4,
    parameter int IDW       = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  bit_in,
    output logic [NREQ-1:0]  grant,
    output logic             bit_rd,
    output logic             det_ain,
    output logic             det_reset,
    input  logic             det_aout,
    output logic             done,
    output logic [IDW-1:0]   done_id,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, REPORT} state_t;

    localparam int BCW = 8;
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   winner_q, winner_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   cand;
    logic [CNT_W-1:0] acc_next;

    // Search from ptr upward with wrap; candidates never reach indices >= NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(ptr_q) + i >= NREQ) begin
                cand = IDW'(int'(ptr_q) + i - NREQ);
            end else begin
                cand = IDW'(int'(ptr_q) + i);
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        acc_next = acc_q;
        if (det_aout && (acc_q != ACC_MAX)) begin
            acc_next = acc_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        done_id_d   = done_id_q;
        hit_count_d = hit_count_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    winner_d = win_idx;
                    grant_d  = NREQ'(1) << win_idx;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                bit_cnt_d = '0;
                acc_d     = '0;
                state_d   = STREAM;
            end
            STREAM: begin
                acc_d     = acc_next;
                bit_cnt_d = bit_cnt_q + BCW'(1);
                // The last bit's hit must land in the reported count.
                if (bit_cnt_q == LAST_BIT) begin
                    state_d     = REPORT;
                    done_id_d   = winner_q;
                    hit_count_d = acc_next;
                    ptr_d       = (winner_q == LAST_ID) ? '0 : winner_q + IDW'(1);
                end
            end
            REPORT: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            winner_q    <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            done_id_q   <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            done_id_q   <= done_id_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign grant     = grant_q;
    assign bit_rd    = (state_q == STREAM);
    assign det_ain   = (state_q == STREAM) ? bit_in[winner_q] : 1'b0;
    assign det_reset = reset | (state_q == CLEAR);
    assign done      = (state_q == REPORT);
    assign done_id   = done_id_q;
    assign hit_count = hit_count_q;

endmodule
